// File: rtl/cap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cap_pkg
//  Description : Shared constants for the CMOS capture burst block: burst
//                length, buffer index width, default geometry and the FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cap_pkg;

    // Pixels per write burst; must be a power of two so the index wraps.
    localparam int BURST_LEN = 8;
    localparam int IDX_W     = $clog2(BURST_LEN);

    // Default sensor geometry and start-up skip count.
    localparam int DEF_WAIT_FRAMES = 10;
    localparam int DEF_H_PIXELS    = 1024;
    localparam int DEF_V_LINES     = 768;

    // Capture FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SKIP    = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cap_burst_buf.sv
`default_nettype none
// ============================================================================
//  Module      : cap_burst_buf
//  Description : 8 x 16 pixel buffer. Pixels are written at a wrapping index;
//                storing the last slot launches an 8-cycle read burst that
//                streams entries 0..7 onto wr_en/wrdata.
//  Revision    : 1.0 - initial release
// ============================================================================
module cap_burst_buf
    import cap_pkg::*;
(
    input  logic             wr_clk,
    input  logic             rst_n,
    input  logic             pix_stb,
    input  logic [15:0]      pix_data,
    input  logic             idx_clr,
    input  logic             abort,
    output logic [IDX_W-1:0] wr_idx,
    output logic             wr_en,
    output logic [15:0]      wrdata
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

    logic [15:0]      mem_q [BURST_LEN];
    logic [15:0]      mem_d [BURST_LEN];
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic             wr_en_q, wr_en_d;
    logic [15:0]      wrdata_q, wrdata_d;
    logic             start;

    // Write port: store pixel, advance index, flag a completed group.
    always_comb begin
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        start    = 1'b0;
        if (abort || idx_clr) begin
            wr_idx_d = '0;
        end else if (pix_stb) begin
            mem_d[wr_idx_q] = pix_data;
            wr_idx_d        = wr_idx_q + 1'b1;
            start           = (wr_idx_q == LAST_IDX);
        end
    end

    // Read sequencer: entry k is registered out at burst cycle k; new pixels
    // (one per two clocks) can only overwrite slots that were already read.
    always_comb begin
        wr_en_d  = wr_en_q;
        rd_idx_d = rd_idx_q;
        wrdata_d = wrdata_q;
        if (abort) begin
            wr_en_d  = 1'b0;
            rd_idx_d = '0;
        end else if (start) begin
            wr_en_d  = 1'b1;
            wrdata_d = mem_q[0];
            rd_idx_d = IDX_W'(1);
        end else if (wr_en_q) begin
            if (rd_idx_q == '0) begin
                wr_en_d = 1'b0;
            end else begin
                wrdata_d = mem_q[rd_idx_q];
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end
    end

    // Pixel storage; contents are don't-care until written.
    always_ff @(posedge wr_clk) begin
        mem_q <= mem_d;
    end

    // Control and output registers.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            wr_en_q  <= 1'b0;
            wrdata_q <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            wr_en_q  <= wr_en_d;
            wrdata_q <= wrdata_d;
        end
    end

    assign wr_idx = wr_idx_q;
    assign wr_en  = wr_en_q;
    assign wrdata = wrdata_q;

endmodule
`default_nettype wire

// File: rtl/cmos_capture_burst.sv
`default_nettype none
// ============================================================================
//  Module      : cmos_capture_burst
//  Description : CMOS sensor RGB565 capture. Skips WAIT_FRAMES frames after
//                configuration, assembles byte pairs into pixels and emits
//                them in 8-pixel bursts; tracks line/frame geometry errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmos_capture_burst
    import cap_pkg::*;
#(
    parameter int WAIT_FRAMES = DEF_WAIT_FRAMES,
    parameter int H_PIXELS    = DEF_H_PIXELS,    // multiple of 8
    parameter int V_LINES     = DEF_V_LINES
)(
    input  logic        wr_clk,
    input  logic        rst_n,
    input  logic        cfg_done,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic        wr_en,
    output logic [15:0] wrdata,
    output logic        frame_start,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err
);

    localparam int SKIP_W = $clog2(WAIT_FRAMES) + 1;
    localparam int PIX_W  = $clog2(H_PIXELS) + 1;
    localparam int LINE_W = $clog2(V_LINES) + 1;

    localparam logic [SKIP_W-1:0] SKIP_TARGET = SKIP_W'(WAIT_FRAMES);
    localparam logic [PIX_W-1:0]  PIX_TARGET  = PIX_W'(H_PIXELS);
    localparam logic [LINE_W-1:0] LINE_TARGET = LINE_W'(V_LINES);

    state_t            state_q, state_d;
    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q, line_err_d;
    logic              frame_err_q, frame_err_d;

    logic              vs_rise, href_fall;
    logic              pix_stb, idx_clr, abort;
    logic [IDX_W-1:0]  buf_idx;

    assign vs_rise   = cam_vsync & ~vsync_q;
    assign href_fall = ~cam_href & href_q;
    assign abort     = ~cfg_done;

    // FSM, byte assembly, geometry counters and error flags.
    always_comb begin
        state_d       = state_q;
        vsync_d       = cam_vsync;
        href_d        = cam_href;
        skip_d        = skip_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_err_d    = line_err_q;
        frame_err_d   = frame_err_q;
        pix_stb       = 1'b0;
        idx_clr       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_done) begin
                    state_d = ST_SKIP;
                    skip_d  = '0;
                end
            end
            ST_SKIP: begin
                if (vs_rise) begin
                    if (skip_q == SKIP_TARGET) begin
                        state_d       = ST_CAPTURE;
                        frame_start_d = 1'b1;
                        line_err_d    = 1'b0;
                        frame_err_d   = 1'b0;
                        line_cnt_d    = '0;
                        pix_cnt_d     = '0;
                        phase_d       = 1'b0;
                        idx_clr       = 1'b1;
                    end else if (skip_q != '1) begin
                        skip_d = skip_q + 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                if (vs_rise) begin
                    // Frame boundary: close the old frame, open the next.
                    frame_done_d  = 1'b1;
                    frame_start_d = 1'b1;
                    frame_err_d   = (line_cnt_q != LINE_TARGET);
                    line_err_d    = 1'b0;
                    line_cnt_d    = '0;
                    pix_cnt_d     = '0;
                    phase_d       = 1'b0;
                    idx_clr       = 1'b1;
                end else if (href_fall) begin
                    // End of line: drop any partial group, check length.
                    if (line_cnt_q != '1) begin
                        line_cnt_d = line_cnt_q + 1'b1;
                    end
                    if ((pix_cnt_q != PIX_TARGET) || (buf_idx != '0) || phase_q) begin
                        line_err_d = 1'b1;
                    end
                    pix_cnt_d = '0;
                    phase_d   = 1'b0;
                    idx_clr   = 1'b1;
                end else if (cam_href) begin
                    if (!phase_q) begin
                        hi_d    = cam_data;
                        phase_d = 1'b1;
                    end else begin
                        pix_stb = 1'b1;
                        phase_d = 1'b0;
                        if (pix_cnt_q != '1) begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Losing configuration overrides everything and parks the block.
        if (!cfg_done) begin
            state_d = ST_IDLE;
            phase_d = 1'b0;
            idx_clr = 1'b1;
            pix_stb = 1'b0;
        end
    end

    // State and control registers.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            skip_q        <= '0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            skip_q        <= skip_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    cap_burst_buf u_buf (
        .wr_clk   (wr_clk),
        .rst_n    (rst_n),
        .pix_stb  (pix_stb),
        .pix_data ({hi_q, cam_data}),
        .idx_clr  (idx_clr),
        .abort    (abort),
        .wr_idx   (buf_idx),
        .wr_en    (wr_en),
        .wrdata   (wrdata)
    );

    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;

endmodule
`default_nettype wire

// File: doc/cmos_capture_burst.md
CMOS_CAPTURE_BURST -- requirements
Module: cmos_capture_burst

Interface
REQ-001 Parameter WAIT_FRAMES, default 10, number of whole frames discarded after cfg_done rises before capture starts.
REQ-002 Parameter H_PIXELS, default 1024, expected pixels per line; SHALL be a multiple of 8.
REQ-003 Parameter V_LINES, default 768, expected lines per frame.
REQ-004 wr_clk  in  1  camera pixel clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cfg_done  in  1  sensor configuration complete; capture enabled only while high.
REQ-007 cam_vsync  in  1  frame sync, active-high.
REQ-008 cam_href  in  1  line valid, active-high.
REQ-009 cam_data  in  8  sensor byte stream, two bytes per RGB565 pixel.
REQ-010 wr_en  out  1  pixel valid to the DDR3 write-FIFO controller; always high in contiguous runs of exactly 8 cycles.
REQ-011 wrdata  out  16  pixel, qualified by wr_en.
REQ-012 frame_start  out  1  one-cycle pulse at the start of each captured frame.
REQ-013 frame_done  out  1  one-cycle pulse at the end of each captured frame.
REQ-014 line_err  out  1  sticky error; cleared on frame_start.
REQ-015 frame_err  out  1  sticky error; cleared on frame_start.

Function
REQ-016 vs_rise SHALL be cam_vsync high with its one-cycle-registered copy low; href_fall is defined the same way for a falling cam_href.
REQ-017 FSM states SHALL be IDLE, SKIP, CAPTURE.
- IDLE -> SKIP when cfg_done=1; skip counter cleared.
- SKIP: each vs_rise increments the skip counter; on the vs_rise at which count==WAIT_FRAMES -> CAPTURE and frame_start pulses; WAIT_FRAMES=0 captures from the first vsync.
- Any state -> IDLE in the cycle after cfg_done=0.
REQ-018 In CAPTURE with cam_href=1, bytes SHALL alternate high/low: first byte -> wrdata[15:8], second -> wrdata[7:0]; the byte phase clears on href_fall.
REQ-019 Each completed pixel SHALL be written to an 8-entry buffer at write index 0..7 (3-bit wrap).
REQ-020 On the edge that stores index 7, a burst SHALL start: wr_en high the next 8 cycles, wrdata = entries 0..7 in order.
REQ-021 Pixels arriving during a burst SHALL be stored from index 0 without loss; entry k is written no earlier than burst cycle k+1.
REQ-022 On href_fall, a partial group (index!=0 or odd byte phase) SHALL be discarded and line_err set; a burst already in progress completes.
REQ-023 Line counter SHALL increment on href_fall in CAPTURE; a line with pixel count != H_PIXELS sets line_err.
REQ-024 On vs_rise in CAPTURE: frame_done and frame_start pulse in the same cycle; frame_err set if line count != V_LINES; line and pixel counters and the buffer index clear.
REQ-025 On exit to IDLE: wr_en drops next cycle (any burst is aborted; the downstream discards the partial group), and the buffer index and byte phase clear.
REQ-026 Counter widths SHALL be $clog2 of the parameter +1; counters saturate, never wrap.

Reset
REQ-027 rst_n low: state IDLE, wr_en=0, wrdata=0, frame_start=0, frame_done=0, line_err=0, frame_err=0, all counters, buffer index and byte phase 0.
REQ-028 Reset SHALL take effect asynchronously mid-burst; after release the block waits for cfg_done and a full WAIT_FRAMES skip again.

Structure
REQ-029 Package cap_pkg SHALL hold the FSM state enum, BURST_LEN=8 and the default parameter constants.
REQ-030 The 8x16 buffer with burst read sequencing SHALL be sub-module cap_burst_buf; the FSM, counters and error flags stay in the top level.

Verification
REQ-031 WAIT_FRAMES=2, cfg_done=1, 3 vsyncs -> no wr_en before the 3rd vs_rise; frame_start pulses exactly once, at the 3rd.
REQ-032 One line, 16 pixels 0x0001..0x0010 (bytes 00,01,00,02,...) -> two 8-cycle wr_en runs, wrdata 0x0001..0x0008 then 0x0009..0x0010; no gaps within a run.
REQ-033 Line of 13 pixels -> one burst of 8; remaining 5 pixels dropped; line_err=1 until next frame_start.
REQ-034 H_PIXELS=16, V_LINES=4, frame of 3 lines then vs_rise -> frame_done=1 and frame_start=1 in the same cycle, frame_err=1.
REQ-035 cfg_done deasserted during burst cycle 3 -> wr_en low from the next cycle; state IDLE.
REQ-036 rst_n pulsed low mid-burst -> all outputs 0 immediately; no wr_en until cfg_done plus WAIT_FRAMES+1 vsyncs.
